// File: rtl/frame_buf_pkg.sv
// Shared definitions for the frame-buffer memory initiator: FSM state encoding,
// active-low enable levels, arbitration grant encoding and default access timing.
package frame_buf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_HOLD = 3'd1,
        ST_RD_HOLD = 3'd2,
        ST_RD_CAP  = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;

    localparam int DEF_HOLD_CYC = 3;
    localparam int DEF_GAP_CYC  = 2;

    function automatic int unsigned max_uint(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_addr_ctr.sv
// Sequential frame address counter: starts at BASE, steps by one on each inc
// and wraps from the last frame address back to BASE.
module frame_addr_ctr #(
    parameter int unsigned BASE       = 1,
    parameter int unsigned SIZE       = 307200,
    parameter int unsigned ADDR_WIDTH = 29
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [63:0] LAST_ADDR_W = 64'(BASE) + 64'(SIZE) - 64'd1;
    localparam logic [ADDR_WIDTH-1:0] C_BASE = ADDR_WIDTH'(BASE);
    localparam logic [ADDR_WIDTH-1:0] C_LAST = LAST_ADDR_W[ADDR_WIDTH-1:0];

    generate
        if (SIZE < 2) begin : g_size_chk
            $error("frame_addr_ctr: SIZE must be at least 2");
        end
        if ((LAST_ADDR_W >> ADDR_WIDTH) != 64'd0) begin : g_width_chk
            $error("frame_addr_ctr: BASE+SIZE-1 does not fit in ADDR_WIDTH");
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_last;

    assign w_last = (r_addr == C_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= C_BASE;
        end else if (inc) begin
            r_addr <= w_last ? C_BASE : (r_addr + ADDR_WIDTH'(1));
        end
    end

    assign addr = r_addr;
    assign last = w_last;

endmodule

// File: rtl/mem_access_ctrl.sv
// Frame-buffer memory initiator: arbitrates a pixel write stream against display
// read requests and sequences the memory's active-low enables with hold/gap timing.
module mem_access_ctrl
    import frame_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 29,
    parameter int unsigned FRAME_SIZE = 307200,
    parameter int unsigned WR_BASE    = 1,
    parameter int unsigned RD_BASE    = 1,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
    parameter int unsigned GAP_CYC    = DEF_GAP_CYC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  px_in_valid,
    output logic                  px_in_ready,
    input  logic [DATA_WIDTH-1:0] px_in_data,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    output logic                  rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] rd_rsp_data,
    output logic                  wr_frame_done,
    output logic                  rd_frame_done,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned CNT_MAX = max_uint(HOLD_CYC, GAP_CYC);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_CYC - 1);

    generate
        if (HOLD_CYC < 1 || GAP_CYC < 1) begin : g_timing_chk
            $error("mem_access_ctrl: HOLD_CYC and GAP_CYC must be at least 1");
        end
    endgenerate

    state_t                r_state, w_state_next;
    logic [CNT_W-1:0]      r_cyc_cnt, w_cyc_cnt_next;
    grant_t                r_last_grant, w_last_grant_next;
    logic                  r_wr_en, w_wr_en_next;
    logic                  r_rd_en, w_rd_en_next;
    logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_next;
    logic                  r_rsp_valid, w_rsp_valid_next;
    logic [DATA_WIDTH-1:0] r_rsp_data, w_rsp_data_next;
    logic                  r_wr_done, w_wr_done_next;
    logic                  r_rd_done, w_rd_done_next;

    logic w_wr_inc, w_rd_inc;
    logic w_wr_last, w_rd_last;
    logic w_px_ready, w_rd_ready;

    frame_addr_ctr #(
        .BASE       (WR_BASE),
        .SIZE       (FRAME_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_wr_inc),
        .addr  (wr_addr),
        .last  (w_wr_last)
    );

    frame_addr_ctr #(
        .BASE       (RD_BASE),
        .SIZE       (FRAME_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_rd_inc),
        .addr  (rd_addr),
        .last  (w_rd_last)
    );

    // When both sides are waiting, the side that did not win last time is served.
    assign w_px_ready = (r_state == ST_IDLE) && (!rd_req_valid || (r_last_grant == GRANT_READ));
    assign w_rd_ready = (r_state == ST_IDLE) && (!px_in_valid  || (r_last_grant == GRANT_WRITE));

    always_comb begin
        w_state_next      = r_state;
        w_cyc_cnt_next    = r_cyc_cnt;
        w_last_grant_next = r_last_grant;
        w_wr_en_next      = DEASSERT_L;
        w_rd_en_next      = DEASSERT_L;
        w_wr_data_next    = r_wr_data;
        w_rsp_valid_next  = 1'b0;
        w_rsp_data_next   = r_rsp_data;
        w_wr_done_next    = 1'b0;
        w_rd_done_next    = 1'b0;
        w_wr_inc          = 1'b0;
        w_rd_inc          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (px_in_valid && w_px_ready) begin
                    w_wr_data_next    = px_in_data;
                    w_wr_en_next      = ASSERT_L;
                    w_last_grant_next = GRANT_WRITE;
                    w_cyc_cnt_next    = '0;
                    w_state_next      = ST_WR_HOLD;
                end else if (rd_req_valid && w_rd_ready) begin
                    w_rd_en_next      = ASSERT_L;
                    w_last_grant_next = GRANT_READ;
                    w_cyc_cnt_next    = '0;
                    w_state_next      = ST_RD_HOLD;
                end
            end

            ST_WR_HOLD: begin
                if (r_cyc_cnt == C_HOLD_LAST) begin
                    w_wr_done_next = w_wr_last;
                    w_wr_inc       = 1'b1;
                    w_cyc_cnt_next = '0;
                    w_state_next   = ST_GAP;
                end else begin
                    w_wr_en_next   = ASSERT_L;
                    w_cyc_cnt_next = r_cyc_cnt + CNT_W'(1);
                end
            end

            ST_RD_HOLD: begin
                if (r_cyc_cnt == C_HOLD_LAST) begin
                    w_state_next = ST_RD_CAP;
                end else begin
                    w_rd_en_next   = ASSERT_L;
                    w_cyc_cnt_next = r_cyc_cnt + CNT_W'(1);
                end
            end

            // The memory has had a full cycle with rd_en released to settle its output.
            ST_RD_CAP: begin
                w_rsp_valid_next = 1'b1;
                w_rsp_data_next  = rd_data;
                w_rd_done_next   = w_rd_last;
                w_rd_inc         = 1'b1;
                w_cyc_cnt_next   = '0;
                w_state_next     = ST_GAP;
            end

            ST_GAP: begin
                if (r_cyc_cnt == C_GAP_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cyc_cnt_next = r_cyc_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cyc_cnt    <= '0;
            r_last_grant <= GRANT_READ;
            r_wr_en      <= DEASSERT_L;
            r_rd_en      <= DEASSERT_L;
            r_wr_data    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_wr_done    <= 1'b0;
            r_rd_done    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cyc_cnt    <= w_cyc_cnt_next;
            r_last_grant <= w_last_grant_next;
            r_wr_en      <= w_wr_en_next;
            r_rd_en      <= w_rd_en_next;
            r_wr_data    <= w_wr_data_next;
            r_rsp_valid  <= w_rsp_valid_next;
            r_rsp_data   <= w_rsp_data_next;
            r_wr_done    <= w_wr_done_next;
            r_rd_done    <= w_rd_done_next;
        end
    end

    assign px_in_ready   = w_px_ready;
    assign rd_req_ready  = w_rd_ready;
    assign rd_rsp_valid  = r_rsp_valid;
    assign rd_rsp_data   = r_rsp_data;
    assign wr_frame_done = r_wr_done;
    assign rd_frame_done = r_rd_done;
    assign wr_data       = r_wr_data;
    assign wr_en         = r_wr_en;
    assign rd_en         = r_rd_en;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a small frame (4 words) exercises wrap, with a
// memory model that only commits a write after a full enable hold.
module tb_mem_access_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 29;
    localparam int FS   = 4;
    localparam int HOLD = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          px_in_valid, px_in_ready;
    logic [DW-1:0] px_in_data;
    logic          rd_req_valid, rd_req_ready;
    logic          rd_rsp_valid;
    logic [DW-1:0] rd_rsp_data;
    logic          wr_frame_done, rd_frame_done;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en, rd_en;
    logic [DW-1:0] rd_data_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FRAME_SIZE (FS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .px_in_valid   (px_in_valid),
        .px_in_ready   (px_in_ready),
        .px_in_data    (px_in_data),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_data   (rd_rsp_data),
        .wr_frame_done (wr_frame_done),
        .rd_frame_done (rd_frame_done),
        .wr_addr       (wr_addr),
        .rd_addr       (rd_addr),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .rd_data       (rd_data_m)
    );

    // Memory model: a write lands only once wr_en has been low for HOLD edges.
    logic [DW-1:0] mem_bus [0:15];
    logic [3:0]    wr_low_cnt;
    logic          mem_init, preload_en;
    logic [3:0]    preload_a;
    logic [DW-1:0] preload_d;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem_bus[i] <= '0;
        end else if (preload_en) begin
            mem_bus[preload_a] <= preload_d;
        end else if (wr_en == 1'b0 && wr_low_cnt == 4'(HOLD - 1)) begin
            mem_bus[wr_addr[3:0]] <= wr_data;
        end
        if (mem_init || wr_en != 1'b0) wr_low_cnt <= '0;
        else                            wr_low_cnt <= wr_low_cnt + 4'd1;
        if (rd_en == 1'b0) rd_data_m <= mem_bus[rd_addr[3:0]];
    end

    // Per-cycle expectation ring used by the random scenario.
    bit            s_wl [8];
    bit            s_rl [8];
    bit            s_rsp [8];
    bit            s_rdone [8];
    bit            s_wdone [8];
    logic [AW-1:0] s_wa [8];
    logic [AW-1:0] s_ra [8];
    logic [DW-1:0] s_wd [8];
    logic [DW-1:0] s_rsd [8];
    logic [DW-1:0] ref_mem [0:FS];

    task automatic apply_reset(input bit clear_mem);
        @(negedge clk);
        reset = 1'b1; mem_init = clear_mem; px_in_valid = 1'b0; rd_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mem_init = 1'b0;
    endtask

    task automatic preload(input logic [3:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        preload_en = 1'b1; preload_a = a; preload_d = d;
        @(negedge clk);
        preload_en = 1'b0;
    endtask

    // Returns just after the accepting edge; the next negedge is access cycle 1.
    task automatic issue_write(input logic [DW-1:0] d);
        int n = 0;
        @(negedge clk);
        px_in_data = d; px_in_valid = 1'b1;
        #1;
        while (px_in_ready !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (px_in_ready !== 1'b1) begin
            errors++; $display("FAIL write_accept: px_in_ready=%b required 1", px_in_ready);
        end
        @(posedge clk); #1;
        px_in_valid = 1'b0;
    endtask

    task automatic issue_read();
        int n = 0;
        @(negedge clk);
        rd_req_valid = 1'b1;
        #1;
        while (rd_req_ready !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (rd_req_ready !== 1'b1) begin
            errors++; $display("FAIL read_accept: rd_req_ready=%b required 1", rd_req_ready);
        end
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        checks += 9;
        if (wr_en !== 1'b1)         begin errors++; $display("FAIL reset_wr_en: got %b required 1", wr_en); end
        if (rd_en !== 1'b1)         begin errors++; $display("FAIL reset_rd_en: got %b required 1", rd_en); end
        if (wr_addr !== AW'(1))     begin errors++; $display("FAIL reset_wr_addr: got %0d required 1", wr_addr); end
        if (rd_addr !== AW'(1))     begin errors++; $display("FAIL reset_rd_addr: got %0d required 1", rd_addr); end
        if (wr_data !== '0)         begin errors++; $display("FAIL reset_wr_data: got %h required 0", wr_data); end
        if (rd_rsp_valid !== 1'b0)  begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rd_rsp_valid); end
        if (rd_rsp_data !== '0)     begin errors++; $display("FAIL reset_rsp_data: got %h required 0", rd_rsp_data); end
        if (wr_frame_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done: got %b required 0", wr_frame_done); end
        if (rd_frame_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done: got %b required 0", rd_frame_done); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b1 || rd_en !== 1'b1 || rd_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: wr_en=%b rd_en=%b rsp=%b required 1 1 0", wr_en, rd_en, rd_rsp_valid);
            end
        end
        checks++;
        if (mem_bus[1] !== '0) begin errors++; $display("FAIL reset_mem: word1=%h required 0", mem_bus[1]); end
        $display("[reset] idle after reset");
    endtask

    task automatic test_single_write();
        issue_write(32'hDEADBEEF);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks += 3;
            if (wr_en !== 1'(k > 3)) begin
                errors++; $display("FAIL sw_wr_en: cycle %0d got %b required %b", k, wr_en, k > 3);
            end
            if (k <= 3 && (wr_addr !== AW'(1) || wr_data !== 32'hDEADBEEF)) begin
                errors++; $display("FAIL sw_bus: cycle %0d addr=%0d data=%h required 1 deadbeef", k, wr_addr, wr_data);
            end
            if (k > 3 && wr_addr !== AW'(2)) begin
                errors++; $display("FAIL sw_next_addr: cycle %0d got %0d required 2", k, wr_addr);
            end
            if (px_in_ready !== 1'(k == 6) || rd_en !== 1'b1 || wr_frame_done !== 1'b0) begin
                errors++;
                $display("FAIL sw_side: cycle %0d ready=%b rd_en=%b done=%b required %b 1 0", k, px_in_ready, rd_en, wr_frame_done, k == 6);
            end
        end
        checks++;
        if (mem_bus[1] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_mem: word1=%h required deadbeef", mem_bus[1]);
        end
        $display("[write] addr=1 data=deadbeef");
    endtask

    task automatic test_single_read();
        preload(4'd1, 32'h12345678);
        issue_read();
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks += 3;
            if (rd_en !== 1'(k > 3)) begin
                errors++; $display("FAIL sr_rd_en: cycle %0d got %b required %b", k, rd_en, k > 3);
            end
            if (k <= 3 && rd_addr !== AW'(1)) begin
                errors++; $display("FAIL sr_addr: cycle %0d got %0d required 1", k, rd_addr);
            end
            if (rd_rsp_valid !== 1'(k == 5) || rd_frame_done !== 1'b0 || rd_req_ready !== 1'(k == 7)) begin
                errors++;
                $display("FAIL sr_rsp: cycle %0d valid=%b done=%b ready=%b required %b 0 %b", k, rd_rsp_valid, rd_frame_done, rd_req_ready, k == 5, k == 7);
            end
            if (k == 5) begin
                checks++;
                if (rd_rsp_data !== 32'h12345678) begin
                    errors++; $display("FAIL sr_data: got %h required 12345678", rd_rsp_data);
                end
            end
        end
        $display("[read] addr=1 data=12345678");
    endtask

    task automatic test_arbitration();
        bit exp_write = 1'b1;
        int last_g = -1;
        int exp_gap = 0;
        int grants = 0;
        int cyc = 0;
        @(negedge clk);
        px_in_valid = 1'b1; rd_req_valid = 1'b1; px_in_data = $urandom();
        while (grants < 8 && cyc < 200) begin
            #1;
            checks++;
            if (wr_en === 1'b0 && rd_en === 1'b0) begin
                errors++; $display("FAIL arb_both_low: wr_en=%b rd_en=%b at cycle %0d", wr_en, rd_en, cyc);
            end
            if (px_in_ready === 1'b1 || rd_req_ready === 1'b1) begin
                checks++;
                if (px_in_ready !== exp_write || rd_req_ready !== !exp_write) begin
                    errors++;
                    $display("FAIL arb_grant: px_ready=%b rd_ready=%b required %b %b", px_in_ready, rd_req_ready, exp_write, !exp_write);
                end
                if (last_g >= 0) begin
                    checks++;
                    if (cyc - last_g != exp_gap) begin
                        errors++; $display("FAIL arb_spacing: got %0d cycles required %0d", cyc - last_g, exp_gap);
                    end
                end
                $display("[arb] grant %s at cycle %0d", exp_write ? "WRITE" : "READ", cyc);
                exp_gap = exp_write ? 6 : 7;
                last_g = cyc;
                grants++;
                exp_write = !exp_write;
            end
            @(negedge clk);
            px_in_data = $urandom();
            cyc++;
        end
        px_in_valid = 1'b0; rd_req_valid = 1'b0;
        checks++;
        if (grants != 8) begin errors++; $display("FAIL arb_timeout: got %0d grants required 8", grants); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d [5];
        logic [DW-1:0] exp_d;
        int done_cnt = 0;
        apply_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            d[i] = $urandom();
            issue_write(d[i]);
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (k <= 3) begin
                    checks++;
                    if (wr_en !== 1'b0 || wr_addr !== AW'(1 + i % FS)) begin
                        errors++; $display("FAIL wrap_wr_addr: write %0d en=%b addr=%0d required 0 %0d", i, wr_en, wr_addr, 1 + i % FS);
                    end
                end
                checks++;
                if (wr_frame_done !== 1'(k == 4 && (i % FS) == FS - 1)) begin
                    errors++; $display("FAIL wrap_wr_done: write %0d cycle %0d got %b", i, k, wr_frame_done);
                end
                if (wr_frame_done === 1'b1) done_cnt++;
            end
            $display("[write] addr=%0d data=%h", 1 + i % FS, d[i]);
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_count: got %0d required 1", done_cnt); end
        for (int j = 0; j < FS; j++) begin
            exp_d = (j == 0) ? d[4] : d[j];
            issue_read();
            for (int k = 1; k <= 7; k++) begin
                @(negedge clk);
                if (k <= 3) begin
                    checks++;
                    if (rd_en !== 1'b0 || rd_addr !== AW'(1 + j)) begin
                        errors++; $display("FAIL wrap_rd_addr: read %0d en=%b addr=%0d required 0 %0d", j, rd_en, rd_addr, 1 + j);
                    end
                end
                checks++;
                if (rd_rsp_valid !== 1'(k == 5) || rd_frame_done !== 1'(k == 5 && j == FS - 1)) begin
                    errors++;
                    $display("FAIL wrap_rd_rsp: read %0d cycle %0d valid=%b done=%b", j, k, rd_rsp_valid, rd_frame_done);
                end
                if (k == 5) begin
                    checks++;
                    if (rd_rsp_data !== exp_d) begin
                        errors++; $display("FAIL wrap_rd_data: read %0d got %h required %h", j, rd_rsp_data, exp_d);
                    end
                end
            end
            $display("[read] addr=%0d data=%h", 1 + j, exp_d);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] old;
        issue_write($urandom());
        repeat (6) @(negedge clk);
        issue_write($urandom());
        repeat (6) @(negedge clk);
        old = mem_bus[4];
        issue_write(~old);
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== AW'(4)) begin
            errors++; $display("FAIL mid_setup: en=%b addr=%0d required 0 4", wr_en, wr_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== AW'(1) || wr_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: en=%b addr=%0d done=%b required 1 1 0", wr_en, wr_addr, wr_frame_done);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b1 || wr_frame_done !== 1'b0 || rd_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_quiet: en=%b done=%b rsp=%b required 1 0 0", wr_en, wr_frame_done, rd_rsp_valid);
            end
        end
        checks++;
        if (mem_bus[4] !== old) begin errors++; $display("FAIL mid_mem: word4=%h required %h", mem_bus[4], old); end
        $display("[reset_mid] write to addr=4 aborted");
    endtask

    task automatic test_random();
        int  idle_at = 0;
        bit  m_last_write = 1'b0;
        int  wp = 0;
        int  rp = 0;
        int  s;
        bit  pxv, rdv, idle, ex_px, ex_rd;
        logic [DW-1:0] d;
        apply_reset(1'b0);
        for (int a = 1; a <= FS; a++) begin
            d = $urandom();
            ref_mem[a] = d;
            preload(4'(a), d);
        end
        for (int i = 0; i < 8; i++) begin
            s_wl[i] = 0; s_rl[i] = 0; s_rsp[i] = 0; s_rdone[i] = 0; s_wdone[i] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            s = cyc % 8;
            checks += 4;
            if (wr_en !== !s_wl[s] || rd_en !== !s_rl[s]) begin
                errors++; $display("FAIL rnd_enables: cycle %0d wr_en=%b rd_en=%b required %b %b", cyc, wr_en, rd_en, !s_wl[s], !s_rl[s]);
            end
            if (rd_rsp_valid !== s_rsp[s]) begin
                errors++; $display("FAIL rnd_rsp_valid: cycle %0d got %b required %b", cyc, rd_rsp_valid, s_rsp[s]);
            end
            if (rd_frame_done !== (s_rsp[s] & s_rdone[s])) begin
                errors++; $display("FAIL rnd_rd_done: cycle %0d got %b required %b", cyc, rd_frame_done, s_rsp[s] & s_rdone[s]);
            end
            if (wr_frame_done !== s_wdone[s]) begin
                errors++; $display("FAIL rnd_wr_done: cycle %0d got %b required %b", cyc, wr_frame_done, s_wdone[s]);
            end
            if (s_wl[s]) begin
                checks++;
                if (wr_addr !== s_wa[s] || wr_data !== s_wd[s]) begin
                    errors++; $display("FAIL rnd_wr_bus: cycle %0d addr=%0d data=%h required %0d %h", cyc, wr_addr, wr_data, s_wa[s], s_wd[s]);
                end
            end
            if (s_rl[s]) begin
                checks++;
                if (rd_addr !== s_ra[s]) begin
                    errors++; $display("FAIL rnd_rd_addr: cycle %0d got %0d required %0d", cyc, rd_addr, s_ra[s]);
                end
            end
            if (s_rsp[s]) begin
                checks++;
                if (rd_rsp_data !== s_rsd[s]) begin
                    errors++; $display("FAIL rnd_rd_data: cycle %0d got %h required %h", cyc, rd_rsp_data, s_rsd[s]);
                end
            end
            s_wl[s] = 0; s_rl[s] = 0; s_rsp[s] = 0; s_rdone[s] = 0; s_wdone[s] = 0;

            pxv = 1'($urandom_range(0, 1));
            rdv = 1'($urandom_range(0, 1));
            d   = $urandom();
            px_in_valid = pxv; rd_req_valid = rdv; px_in_data = d;
            #1;
            idle  = (cyc >= idle_at);
            ex_px = idle && (!rdv || !m_last_write);
            ex_rd = idle && (!pxv || m_last_write);
            checks++;
            if (px_in_ready !== ex_px || rd_req_ready !== ex_rd) begin
                errors++; $display("FAIL rnd_ready: cycle %0d px=%b rd=%b required %b %b", cyc, px_in_ready, rd_req_ready, ex_px, ex_rd);
            end
            if (pxv && ex_px) begin
                for (int k = 1; k <= 3; k++) begin
                    s_wl[(cyc + k) % 8] = 1; s_wa[(cyc + k) % 8] = AW'(1 + wp); s_wd[(cyc + k) % 8] = d;
                end
                s_wdone[(cyc + 4) % 8] = (wp == FS - 1);
                ref_mem[1 + wp] = d;
                $display("[write] cycle %0d addr=%0d data=%h", cyc, 1 + wp, d);
                wp = (wp + 1) % FS;
                m_last_write = 1'b1;
                idle_at = cyc + 6;
            end else if (rdv && ex_rd) begin
                for (int k = 1; k <= 3; k++) begin
                    s_rl[(cyc + k) % 8] = 1; s_ra[(cyc + k) % 8] = AW'(1 + rp);
                end
                s_rsp[(cyc + 5) % 8] = 1;
                s_rsd[(cyc + 5) % 8] = ref_mem[1 + rp];
                s_rdone[(cyc + 5) % 8] = (rp == FS - 1);
                $display("[read] cycle %0d addr=%0d data=%h", cyc, 1 + rp, ref_mem[1 + rp]);
                rp = (rp + 1) % FS;
                m_last_write = 1'b0;
                idle_at = cyc + 7;
            end
        end
        px_in_valid = 1'b0; rd_req_valid = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_init = 1'b1; preload_en = 1'b0; preload_a = '0; preload_d = '0;
        px_in_valid = 1'b0; rd_req_valid = 1'b0; px_in_data = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_arbitration();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
